// File: rtl/grab_trigger_ctrl.sv
// Grab/trigger sequencer for the XGS sensor datapath: arm, qualify trigger, delay, fire, wait ready.
// Optional HW trigger glitch filter enabled by defining GRAB_HW_TRIG_FILTER_EN.
module grab_trigger_ctrl #(
   parameter int DLY_W    = 16,
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 4
) (
   input  logic             sys_clk,
   input  logic             sys_reset_n,
   input  logic             grab_cmd,
   input  logic             grab_stop,
   input  logic [2:0]       grab_src,
   input  logic [2:0]       grab_act,
   input  logic             hw_trig_in,
   input  logic             sw_trig,
   input  logic             sfnc_trig,
   input  logic [DLY_W-1:0] trig_delay,
   input  logic             sensor_ready,
   output logic             frame_start,
   output logic             grab_active,
   output logic             cfg_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] missed_cnt,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_DELAY = 3'd2,
      S_FIRE  = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   localparam logic [2:0] SRC_IMM  = 3'd1;
   localparam logic [2:0] SRC_HW   = 3'd2;
   localparam logic [2:0] SRC_SW   = 3'd3;
   localparam logic [2:0] SRC_SFNC = 3'd4;

   localparam logic [2:0] ACT_RISE = 3'd0;
   localparam logic [2:0] ACT_FALL = 3'd1;
   localparam logic [2:0] ACT_ANY  = 3'd2;
   localparam logic [2:0] ACT_HI   = 3'd3;
   localparam logic [2:0] ACT_LO   = 3'd4;

   state_t           state_q, state_d;
   logic [2:0]       src_q, act_q;
   logic [DLY_W-1:0] dly_q, dly_cnt;
   logic             stop_pend;
   logic             cfg_err_q;

   logic hw_s1, hw_s2, hw_q, hw_prev, hw_sig;
   logic sw_prev, sfnc_prev;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         hw_s1 <= 1'b0;
         hw_s2 <= 1'b0;
      end else begin
         hw_s1 <= hw_trig_in;
         hw_s2 <= hw_s1;
      end
   end

`ifdef GRAB_HW_TRIG_FILTER_EN
   localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   logic            hw_filt;
   logic [FC_W-1:0] filt_cnt;

   // Output follows the input only after FILT_LEN consecutive disagreeing samples.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         hw_filt  <= 1'b0;
         filt_cnt <= '0;
      end else if (hw_s2 == hw_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
         hw_filt  <= hw_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end
   assign hw_sig = hw_filt;
`else
   assign hw_sig = hw_s2;
`endif

   // Edge/prev registers run in every state so busy-time edges can be counted as missed.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         hw_q      <= 1'b0;
         hw_prev   <= 1'b0;
         sw_prev   <= 1'b0;
         sfnc_prev <= 1'b0;
      end else begin
         hw_q      <= hw_sig;
         hw_prev   <= hw_q;
         sw_prev   <= sw_trig;
         sfnc_prev <= sfnc_trig;
      end
   end

   logic cur_sig, prev_sig, qual_evt, trig_evt, missed_evt, cfg_valid, busy;

   always_comb begin
      cur_sig  = 1'b0;
      prev_sig = 1'b0;
      case (src_q)
         SRC_HW:   begin cur_sig = hw_q;      prev_sig = hw_prev;   end
         SRC_SW:   begin cur_sig = sw_trig;   prev_sig = sw_prev;   end
         SRC_SFNC: begin cur_sig = sfnc_trig; prev_sig = sfnc_prev; end
         default:  ;
      endcase
   end

   always_comb begin
      qual_evt = 1'b0;
      case (act_q)
         ACT_RISE: qual_evt = cur_sig & ~prev_sig;
         ACT_FALL: qual_evt = ~cur_sig & prev_sig;
         ACT_ANY:  qual_evt = cur_sig ^ prev_sig;
         ACT_HI:   qual_evt = cur_sig;
         ACT_LO:   qual_evt = ~cur_sig;
         default:  qual_evt = 1'b0;
      endcase
   end

   assign trig_evt   = (src_q == SRC_IMM) | qual_evt;
   assign missed_evt = (src_q != SRC_IMM) & (act_q <= ACT_ANY) & qual_evt;
   assign cfg_valid  = (grab_src >= SRC_IMM) & (grab_src <= SRC_SFNC) & (grab_act <= ACT_LO);
   assign busy       = (state_q == S_DELAY) | (state_q == S_FIRE) | (state_q == S_WAIT);

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) state_q <= S_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grab_cmd && cfg_valid) state_d = S_ARMED;
         S_ARMED: if (grab_stop)             state_d = S_IDLE;
                  else if (trig_evt)         state_d = S_DELAY;
         S_DELAY: if (grab_stop)             state_d = S_IDLE;
                  else if (dly_cnt == '0)    state_d = S_FIRE;
         S_FIRE:                             state_d = S_WAIT;
         S_WAIT:  if (sensor_ready)          state_d = (stop_pend | grab_stop) ? S_IDLE : S_ARMED;
         default:                            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         src_q      <= '0;
         act_q      <= '0;
         dly_q      <= '0;
         dly_cnt    <= '0;
         stop_pend  <= 1'b0;
         cfg_err_q  <= 1'b0;
         frame_cnt  <= '0;
         missed_cnt <= '0;
      end else begin
         cfg_err_q <= (state_q == S_IDLE) & grab_cmd & ~cfg_valid;
         if (state_q == S_IDLE && grab_cmd && cfg_valid) begin
            src_q <= grab_src;
            act_q <= grab_act;
            dly_q <= trig_delay;
         end
         if (state_q == S_ARMED && !grab_stop && trig_evt)
            dly_cnt <= dly_q;
         else if (state_q == S_DELAY && dly_cnt != '0)
            dly_cnt <= dly_cnt - 1'b1;
         // A stop during FIRE/WAIT_RDY lets the current frame finish first.
         if (state_q == S_IDLE)
            stop_pend <= 1'b0;
         else if ((state_q == S_FIRE || state_q == S_WAIT) && grab_stop)
            stop_pend <= 1'b1;
         if (state_q == S_FIRE)
            frame_cnt <= frame_cnt + 1'b1;
         if (busy && missed_evt && missed_cnt != '1)
            missed_cnt <= missed_cnt + 1'b1;
      end
   end

   always_comb begin
      frame_start = (state_q == S_FIRE);
      grab_active = (state_q != S_IDLE);
      cfg_err     = cfg_err_q;
      state_o     = state_q;
   end

endmodule
